// File: rtl/myo_spi_pkg.sv
// Shared definitions for the myo SPI link: frame layout, word indices, FSM states
// and the status snapshot layout used by master and responder alike.
package myo_spi_pkg;

  localparam int          SPI_FRAME_WORDS = 10;
  localparam logic [15:0] HEADER_WORD     = 16'h8000;
  localparam logic [7:0]  FRAME_WORDS_CNT = 8'(SPI_FRAME_WORDS);

  localparam logic [7:0] IDX_HDR     = 8'd0;
  localparam logic [7:0] IDX_PWM     = 8'd1;
  localparam logic [7:0] IDX_CTRL    = 8'd2;
  localparam logic [7:0] IDX_POS_L   = 8'd3;
  localparam logic [7:0] IDX_POS_H   = 8'd4;
  localparam logic [7:0] IDX_VEL     = 8'd5;
  localparam logic [7:0] IDX_CUR     = 8'd6;
  localparam logic [7:0] IDX_DISP_L  = 8'd7;
  localparam logic [7:0] IDX_DISP_H  = 8'd8;
  localparam logic [7:0] IDX_SENSOR1 = 8'd9;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACTIVE = 2'd1;
  localparam state_t ST_COMMIT = 2'd2;

  // 112-bit motor status snapshot, frozen at the start of every frame
  typedef struct packed {
    logic [31:0] position;
    logic [15:0] velocity;
    logic [15:0] current;
    logic [31:0] displacement;
    logic [15:0] sensor1;
  } status_t;

  function automatic logic [7:0] satInc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/myo_spi_tx_mux.sv
// Maps the tx word index onto the frozen status snapshot; 32-bit values go low half first.
module myo_spi_tx_mux
  import myo_spi_pkg::*;
(
  input  logic [7:0]  txCnt_i,
  input  status_t     shadow_i,
  output logic [15:0] word_o
);

  always_comb begin
    word_o = 16'h0000;
    case (txCnt_i)
      IDX_POS_L:   word_o = shadow_i.position[15:0];
      IDX_POS_H:   word_o = shadow_i.position[31:16];
      IDX_VEL:     word_o = shadow_i.velocity;
      IDX_CUR:     word_o = shadow_i.current;
      IDX_DISP_L:  word_o = shadow_i.displacement[15:0];
      IDX_DISP_H:  word_o = shadow_i.displacement[31:16];
      IDX_SENSOR1: word_o = shadow_i.sensor1;
      default:     word_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/myo_spi_responder.sv
// Motorboard-side frame controller for the myo SPI link (FPGA motorboard emulation).
// Optional link watchdog enabled by defining MYO_RESPONDER_WATCHDOG_EN.
module myo_spi_responder
  import myo_spi_pkg::*;
#(
  parameter int unsigned WATCHDOG_CYCLES = 5000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ss_n,
  input  logic               di_req,
  input  logic               write_ack,
  input  logic               data_read_valid,
  input  logic        [15:0] data_read,
  input  logic signed [31:0] position,
  input  logic signed [15:0] velocity,
  input  logic signed [15:0] current,
  input  logic signed [31:0] displacement,
  input  logic signed [15:0] sensor1,
  output logic        [15:0] Word,
  output logic               wren,
  output logic signed [15:0] pwm_ref,
  output logic        [15:0] control_flag,
  output logic               frame_valid,
  output logic               frame_error,
  output logic        [15:0] error_count,
  output logic               link_timeout
);

  state_t      state_q, state_d;
  logic        ssPrev_q, diReqPrev_q, wackPrev_q, drvPrev_q;
  logic [7:0]  rxCnt_q, rxCnt_d, txCnt_q, txCnt_d;
  logic        hdrBad_q, hdrBad_d;
  logic [15:0] pwmStage_q, pwmStage_d, ctrlStage_q, ctrlStage_d;
  status_t     shadow_q, shadow_d;
  logic [15:0] word_q, word_d;
  logic        wren_q, wren_d;
  logic [15:0] pwmRef_q, pwmRef_d, ctrlFlag_q, ctrlFlag_d;
  logic        frameValid_q, frameValid_d, frameError_q, frameError_d;
  logic [15:0] errCnt_q, errCnt_d;
  logic [15:0] txWord;
  logic        ssFall, ssRise, diRise, wackRise, drvFall;
  logic        commitOk, wdFire;

  assign ssFall   = ssPrev_q & ~ss_n;
  assign ssRise   = ~ssPrev_q & ss_n;
  assign diRise   = ~diReqPrev_q & di_req;
  assign wackRise = ~wackPrev_q & write_ack;
  assign drvFall  = drvPrev_q & ~data_read_valid;
  assign commitOk = (state_q == ST_COMMIT) && (rxCnt_q == FRAME_WORDS_CNT) && !hdrBad_q;

  myo_spi_tx_mux uTxMux (
    .txCnt_i  (txCnt_q),
    .shadow_i (shadow_q),
    .word_o   (txWord)
  );

  always_comb begin
    state_d      = state_q;
    rxCnt_d      = rxCnt_q;
    txCnt_d      = txCnt_q;
    hdrBad_d     = hdrBad_q;
    pwmStage_d   = pwmStage_q;
    ctrlStage_d  = ctrlStage_q;
    shadow_d     = shadow_q;
    word_d       = word_q;
    wren_d       = wren_q;
    pwmRef_d     = pwmRef_q;
    ctrlFlag_d   = ctrlFlag_q;
    frameValid_d = 1'b0;
    frameError_d = 1'b0;
    errCnt_d     = errCnt_q;

    case (state_q)
      ST_IDLE: begin
        if (ssFall) begin
          state_d               = ST_ACTIVE;
          rxCnt_d               = 8'd0;
          txCnt_d               = 8'd0;
          hdrBad_d              = 1'b0;
          wren_d                = 1'b0;
          shadow_d.position     = position;
          shadow_d.velocity     = velocity;
          shadow_d.current      = current;
          shadow_d.displacement = displacement;
          shadow_d.sensor1      = sensor1;
        end
      end
      ST_ACTIVE: begin
        // A word completing together with ss_n rising still counts toward this frame
        if (drvFall) begin
          if (rxCnt_q == IDX_HDR)  hdrBad_d    = (data_read != HEADER_WORD);
          if (rxCnt_q == IDX_PWM)  pwmStage_d  = data_read;
          if (rxCnt_q == IDX_CTRL) ctrlStage_d = data_read;
          rxCnt_d = satInc8(rxCnt_q);
        end
        if (wackRise) begin
          wren_d  = 1'b0;
          txCnt_d = satInc8(txCnt_q);
        end
        if (diRise && !wren_q) begin
          word_d = txWord;
          wren_d = 1'b1;
        end
        if (ssRise) begin
          wren_d  = 1'b0;
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (commitOk) begin
          pwmRef_d     = pwmStage_q;
          ctrlFlag_d   = ctrlStage_q;
          frameValid_d = 1'b1;
        end else begin
          frameError_d = 1'b1;
          if (errCnt_q != 16'hFFFF) errCnt_d = errCnt_q + 16'd1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (wdFire && !commitOk) pwmRef_d = 16'h0000;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ssPrev_q     <= 1'b0;
      diReqPrev_q  <= 1'b0;
      wackPrev_q   <= 1'b0;
      drvPrev_q    <= 1'b0;
      rxCnt_q      <= 8'd0;
      txCnt_q      <= 8'd0;
      hdrBad_q     <= 1'b0;
      pwmStage_q   <= 16'h0000;
      ctrlStage_q  <= 16'h0000;
      shadow_q     <= '0;
      word_q       <= 16'h0000;
      wren_q       <= 1'b0;
      pwmRef_q     <= 16'h0000;
      ctrlFlag_q   <= 16'h0000;
      frameValid_q <= 1'b0;
      frameError_q <= 1'b0;
      errCnt_q     <= 16'h0000;
    end else begin
      state_q      <= state_d;
      ssPrev_q     <= ss_n;
      diReqPrev_q  <= di_req;
      wackPrev_q   <= write_ack;
      drvPrev_q    <= data_read_valid;
      rxCnt_q      <= rxCnt_d;
      txCnt_q      <= txCnt_d;
      hdrBad_q     <= hdrBad_d;
      pwmStage_q   <= pwmStage_d;
      ctrlStage_q  <= ctrlStage_d;
      shadow_q     <= shadow_d;
      word_q       <= word_d;
      wren_q       <= wren_d;
      pwmRef_q     <= pwmRef_d;
      ctrlFlag_q   <= ctrlFlag_d;
      frameValid_q <= frameValid_d;
      frameError_q <= frameError_d;
      errCnt_q     <= errCnt_d;
    end
  end

`ifdef MYO_RESPONDER_WATCHDOG_EN
  logic [31:0] wdCnt_q;
  logic        linkTimeout_q;

  // Counter parks at the limit so the timeout stays asserted until a good frame
  assign wdFire = (wdCnt_q == WATCHDOG_CYCLES);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdCnt_q       <= 32'd0;
      linkTimeout_q <= 1'b0;
    end else if (commitOk) begin
      wdCnt_q       <= 32'd0;
      linkTimeout_q <= 1'b0;
    end else if (wdFire) begin
      linkTimeout_q <= 1'b1;
    end else begin
      wdCnt_q <= wdCnt_q + 32'd1;
    end
  end

  assign link_timeout = linkTimeout_q;
`else
  logic unusedWatchdog;
  assign unusedWatchdog = ^WATCHDOG_CYCLES;
  assign wdFire         = 1'b0;
  assign link_timeout   = 1'b0;
`endif

  assign Word         = word_q;
  assign wren         = wren_q;
  assign pwm_ref      = pwmRef_q;
  assign control_flag = ctrlFlag_q;
  assign frame_valid  = frameValid_q;
  assign frame_error  = frameError_q;
  assign error_count  = errCnt_q;

endmodule

// File: tb/tb_myo_spi_responder.sv
// Directed bench for myo_spi_responder: table of whole frames plus snapshot, reset and watchdog sequences.
module tb_myo_spi_responder;

  logic               clock = 1'b0;
  logic               reset;
  logic               ss_n, di_req, write_ack, data_read_valid;
  logic        [15:0] data_read;
  logic signed [31:0] position, displacement;
  logic signed [15:0] velocity, current, sensor1;
  logic        [15:0] Word;
  logic               wren;
  logic signed [15:0] pwm_ref;
  logic        [15:0] control_flag;
  logic               frame_valid, frame_error;
  logic        [15:0] error_count;
  logic               link_timeout;

  int tests = 0;
  int failures = 0;
  int validCycles, errorCycles;
  logic [15:0] txWords [0:15];

  typedef struct {
    logic [15:0] hdr, pwm, ctrl;
    int          nWords;
    logic [31:0] pos;
    logic [15:0] vel;
    int          expValid, expError;
    logic [15:0] expPwm, expCtrl, expErrCnt, expW3, expW4, expW5;
  } vec_t;

  localparam int NVEC = 7;
  vec_t vec [NVEC];

  always #5 clock = ~clock;

  myo_spi_responder #(.WATCHDOG_CYCLES(100)) dut (
    .clock           (clock),
    .reset           (reset),
    .ss_n            (ss_n),
    .di_req          (di_req),
    .write_ack       (write_ack),
    .data_read_valid (data_read_valid),
    .data_read       (data_read),
    .position        (position),
    .velocity        (velocity),
    .current         (current),
    .displacement    (displacement),
    .sensor1         (sensor1),
    .Word            (Word),
    .wren            (wren),
    .pwm_ref         (pwm_ref),
    .control_flag    (control_flag),
    .frame_valid     (frame_valid),
    .frame_error     (frame_error),
    .error_count     (error_count),
    .link_timeout    (link_timeout)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One word exchanged in both directions, as the SPI core would present it
  task automatic doWord(input logic [15:0] rxw, input bit expectTx, output logic [15:0] txw);
    int k;
    data_read = rxw;
    data_read_valid = 1'b1;
    di_req = 1'b1;
    tick();
    if (expectTx) begin
      k = 0;
      while (!wren && k < 10) begin
        tick();
        k++;
      end
      checkOutput("wrenUp", 16'(wren), 16'd1);
    end else begin
      checkOutput("wrenIdle", 16'(wren), 16'd0);
    end
    txw = Word;
    write_ack = 1'b1;
    di_req = 1'b0;
    data_read_valid = 1'b0;
    tick();
    write_ack = 1'b0;
    tick();
  endtask

  task automatic watchPulses();
    validCycles = 0;
    errorCycles = 0;
    repeat (5) begin
      tick();
      if (frame_valid) validCycles++;
      if (frame_error) errorCycles++;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] w0, w1, w2, input int n,
                               input int changeAt, input logic [31:0] newPos);
    logic [15:0] rxw, txw;
    ss_n = 1'b0;
    tick();
    tick();
    for (int i = 0; i < n; i++) begin
      if (i == changeAt) position = newPos;
      rxw = (i == 0) ? w0 : (i == 1) ? w1 : (i == 2) ? w2 : 16'h00F0 + 16'(i);
      doWord(rxw, 1'b1, txw);
      txWords[i] = txw;
    end
    ss_n = 1'b1;
    watchPulses();
    checkOutput("wrenAfterFrame", 16'(wren), 16'd0);
  endtask

  initial begin
    logic [15:0] exp;
    logic [15:0] dummy;

    vec[0] = '{16'h8000, 16'h0123, 16'h0005, 10, 32'h11112222, 16'hFFFD, 1, 0, 16'h0123, 16'h0005, 16'd0, 16'h2222, 16'h1111, 16'hFFFD};
    vec[1] = '{16'h8001, 16'h0456, 16'h0007, 10, 32'h11112222, 16'hFFFD, 0, 1, 16'h0123, 16'h0005, 16'd1, 16'h2222, 16'h1111, 16'hFFFD};
    vec[2] = '{16'h8000, 16'h0456, 16'h0006, 10, 32'hDEADBEEF, 16'h7FFF, 1, 0, 16'h0456, 16'h0006, 16'd1, 16'hBEEF, 16'hDEAD, 16'h7FFF};
    vec[3] = '{16'h8000, 16'h0777, 16'h0009,  6, 32'hDEADBEEF, 16'h7FFF, 0, 1, 16'h0456, 16'h0006, 16'd2, 16'hBEEF, 16'hDEAD, 16'h7FFF};
    vec[4] = '{16'h8000, 16'hFF00, 16'h00AA, 10, 32'h00000000, 16'h8000, 1, 0, 16'hFF00, 16'h00AA, 16'd2, 16'h0000, 16'h0000, 16'h8000};
    vec[5] = '{16'h8000, 16'h0888, 16'h000A, 11, 32'h00000000, 16'h8000, 0, 1, 16'hFF00, 16'h00AA, 16'd3, 16'h0000, 16'h0000, 16'h8000};
    vec[6] = '{16'h8000, 16'h0001, 16'h0002, 10, 32'h12345678, 16'h0001, 1, 0, 16'h0001, 16'h0002, 16'd3, 16'h5678, 16'h1234, 16'h0001};

    reset = 1'b1;
    ss_n = 1'b1;
    di_req = 1'b0;
    write_ack = 1'b0;
    data_read_valid = 1'b0;
    data_read = 16'h0000;
    position = 32'sh0;
    velocity = 16'sh0;
    current = 16'sh1234;
    displacement = 32'shCAFEBABE;
    sensor1 = 16'sh5A5A;
    repeat (3) tick();

    checkOutput("rstWord", Word, 16'h0000);
    checkOutput("rstWren", 16'(wren), 16'd0);
    checkOutput("rstPwm", pwm_ref, 16'h0000);
    checkOutput("rstCtrl", control_flag, 16'h0000);
    checkOutput("rstErrCnt", error_count, 16'h0000);
    checkOutput("rstPulses", {14'd0, frame_valid, frame_error}, 16'd0);
    checkOutput("rstTimeout", 16'(link_timeout), 16'd0);

    reset = 1'b0;
    tick();

    for (int v = 0; v < NVEC; v++) begin
      position = vec[v].pos;
      velocity = vec[v].vel;
      applyStimulus(vec[v].hdr, vec[v].pwm, vec[v].ctrl, vec[v].nWords, -1, 32'h0);
      checkOutput($sformatf("v%0d.validPulse", v), 16'(validCycles), 16'(vec[v].expValid));
      checkOutput($sformatf("v%0d.errorPulse", v), 16'(errorCycles), 16'(vec[v].expError));
      checkOutput($sformatf("v%0d.pwmRef", v), pwm_ref, vec[v].expPwm);
      checkOutput($sformatf("v%0d.ctrlFlag", v), control_flag, vec[v].expCtrl);
      checkOutput($sformatf("v%0d.errCount", v), error_count, vec[v].expErrCnt);
      for (int i = 0; i < vec[v].nWords; i++) begin
        case (i)
          3:       exp = vec[v].expW3;
          4:       exp = vec[v].expW4;
          5:       exp = vec[v].expW5;
          6:       exp = 16'h1234;
          7:       exp = 16'hBABE;
          8:       exp = 16'hCAFE;
          9:       exp = 16'h5A5A;
          default: exp = 16'h0000;
        endcase
        checkOutput($sformatf("v%0d.tx%0d", v, i), txWords[i], exp);
      end
    end

    // Position crosses a 16-bit boundary between the two halves being sent
    position = 32'h0000FFFF;
    velocity = 16'sh0;
    applyStimulus(16'h8000, 16'h0321, 16'h0004, 10, 4, 32'h00010000);
    checkOutput("snapTx3", txWords[3], 16'hFFFF);
    checkOutput("snapTx4", txWords[4], 16'h0000);
    checkOutput("snapValid", 16'(validCycles), 16'd1);
    checkOutput("snapPwm", pwm_ref, 16'h0321);

    // Reset in the middle of a frame, released while ss_n is still low
    ss_n = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) doWord((i == 0) ? 16'h8000 : 16'h0555, 1'b1, dummy);
    reset = 1'b1;
    tick();
    checkOutput("midRstPwm", pwm_ref, 16'h0000);
    checkOutput("midRstCtrl", control_flag, 16'h0000);
    checkOutput("midRstErrCnt", error_count, 16'h0000);
    checkOutput("midRstWord", Word, 16'h0000);
    checkOutput("midRstWren", 16'(wren), 16'd0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) doWord(16'h0666, 1'b0, dummy);
    ss_n = 1'b1;
    watchPulses();
    checkOutput("orphanValid", 16'(validCycles), 16'd0);
    checkOutput("orphanError", 16'(errorCycles), 16'd0);
    position = 32'h0BADF00D;
    applyStimulus(16'h8000, 16'h0ABC, 16'h0003, 10, -1, 32'h0);
    checkOutput("postRstValid", 16'(validCycles), 16'd1);
    checkOutput("postRstPwm", pwm_ref, 16'h0ABC);
    checkOutput("postRstCtrl", control_flag, 16'h0003);
    checkOutput("postRstErrCnt", error_count, 16'h0000);
    checkOutput("postRstTx3", txWords[3], 16'hF00D);
    checkOutput("postRstTx4", txWords[4], 16'h0BAD);

`ifdef MYO_RESPONDER_WATCHDOG_EN
    begin
      int k = 0;
      while (!link_timeout && k < 300) begin
        tick();
        k++;
      end
    end
    checkOutput("wdTimeout", 16'(link_timeout), 16'd1);
    checkOutput("wdPwmZero", pwm_ref, 16'h0000);
    checkOutput("wdCtrlKept", control_flag, 16'h0003);
    applyStimulus(16'h8000, 16'h0042, 16'h0007, 10, -1, 32'h0);
    checkOutput("wdCleared", 16'(link_timeout), 16'd0);
    checkOutput("wdPwmCommit", pwm_ref, 16'h0042);
`else
    repeat (150) tick();
    checkOutput("noWdTimeout", 16'(link_timeout), 16'd0);
    checkOutput("noWdPwmKept", pwm_ref, 16'h0ABC);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/myo_spi_responder.md
Name: myo_spi_responder

Overview:
- Slave-side frame controller: the motorboard end of the myo SPI link, emulating a motorboard inside the FPGA for loopback and hardware-in-the-loop tests.
- Sits behind a word-level SPI slave core and decodes each 10-word master frame: header 0x8000, pwmRef, controlFlag, then filler words.
- Answers each frame with a snapshot of the emulated motor status in words 3..9, low half first for 32-bit values.
- Commits pwm_ref and control_flag only after a complete, valid frame.

Parameters:
- SPI_FRAME_WORDS, 10: words per frame.
- HEADER_WORD, 16'h8000: required value of received word 0.
- WATCHDOG_CYCLES, 5000000: frame-timeout period in clock cycles (100 ms at 50 MHz). Used only with the optional feature.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- ss_n  in  1  slave select, already synchronized to clock; low = frame active.
- di_req  in  1  core requests the next tx word; rising edge is significant.
- write_ack  in  1  core accepted Word; rising edge is significant.
- data_read_valid  in  1  rx word valid; data is taken on the falling edge.
- data_read  in  16  received word.
- position  in  32 signed  emulated motor status.
- velocity  in  16 signed  emulated motor status.
- current  in  16 signed  emulated motor status.
- displacement  in  32 signed  emulated motor status.
- sensor1  in  16 signed  emulated motor status.
- Word  out  16  tx word to the core.
- wren  out  1  tx word valid; held until write_ack.
- pwm_ref  out  16 signed  committed PWM reference.
- control_flag  out  16  committed control flags.
- frame_valid  out  1  1-cycle pulse on commit.
- frame_error  out  1  1-cycle pulse on a bad header, short frame or long frame.
- error_count  out  16  saturating count of errored frames.
- link_timeout  out  1  watchdog expired (optional feature only).

Behaviour:
- Reset values:
  - Word, pwm_ref, control_flag, error_count = 0.
  - wren, frame_valid, frame_error, link_timeout = 0.
  - State IDLE; rx_cnt and tx_cnt = 0.
- Edge detection: registered previous values of ss_n, di_req, write_ack and data_read_valid.
- States:
  - IDLE: ss_n=1.
    - ss_n falling → ACTIVE.
    - Clear rx_cnt, tx_cnt, hdr_bad and wren.
    - Snapshot all status inputs into a 112-bit shadow in the same cycle, so both halves of position and displacement are coherent.
  - ACTIVE:
    - ss_n rising → COMMIT.
    - ss_n rising in the same cycle as a data_read_valid falling edge: capture the word first, then evaluate it in COMMIT.
  - COMMIT (1 cycle):
    - rx_cnt==SPI_FRAME_WORDS and !hdr_bad: pwm_ref and control_flag take the staging registers; frame_valid=1.
    - Otherwise: frame_error=1 and error_count+1, saturating at 16'hFFFF. pwm_ref and control_flag are unchanged.
    - Then → IDLE.
- Rx path, on each data_read_valid falling edge in ACTIVE:
  - rx_cnt 0: hdr_bad = (data_read != HEADER_WORD).
  - rx_cnt 1: stage pwm_ref.
  - rx_cnt 2: stage control_flag.
  - Other indices: discarded.
  - rx_cnt increments and saturates at 255. rx_cnt > SPI_FRAME_WORDS is a long-frame error.
- Tx path:
  - A di_req rising edge in ACTIVE with wren=0 loads Word from tx_cnt; wren=1 the next cycle.
  - A di_req edge while wren=1 is ignored.
  - write_ack rising edge: wren=0, tx_cnt+1 (saturating).
  - Word by tx_cnt:
    - 0..2: 16'h0000.
    - 3: pos[15:0]; 4: pos[31:16].
    - 5: velocity; 6: current.
    - 7: disp[15:0]; 8: disp[31:16].
    - 9: sensor1.
    - ≥10: 16'h0000.
  - ss_n rising aborts any pending wren (wren=0).
- Reset mid-frame: everything returns to reset values. A frame in progress at reset release is ignored until ss_n has been seen high (IDLE requires ss_n=1 before arming).

Optional Feature:
- Macro MYO_RESPONDER_WATCHDOG_EN.
- Defined:
  - A 32-bit counter increments every cycle and clears on frame_valid.
  - When it reaches WATCHDOG_CYCLES: link_timeout=1 and pwm_ref forced to 0; control_flag is kept.
  - The next frame_valid clears link_timeout and commits normally.
- Undefined: link_timeout tied to 0, no counter, and the parameter is unused.

Decomposition:
- Shared package myo_spi_pkg:
  - SPI_FRAME_WORDS, HEADER_WORD.
  - Word-index constants (IDX_PWM=1, IDX_CTRL=2, IDX_POS_L=3 … IDX_SENSOR1=9).
  - State enum.
  - The master controller uses the same package.
- Sub-module myo_spi_tx_mux: combinational mapping of tx_cnt plus the status shadow to Word data. Natural, but optional.

Test Plan:
- Nominal frame: 8000, 0123, 0005, then 7 filler words; position=0x11112222, velocity=-3 → frame_valid pulse, pwm_ref=0x0123, control_flag=5; tx words 3/4 = 2222/1111, word 5 = FFFD.
- Bad header: word0 = 0x8001 → frame_error pulse, error_count=1, pwm_ref unchanged.
- Short frame: ss_n rises after 6 words → frame_error pulse, outputs unchanged, wren=0.
- Snapshot coherence: position changes from 0x0000FFFF to 0x00010000 between tx words 3 and 4 → master reads FFFF/0000.
- Reset asserted mid-frame at word 4 → all outputs 0; the next full frame after ss_n has been high commits normally.
- MYO_RESPONDER_WATCHDOG_EN with WATCHDOG_CYCLES=100: no frame for 100 cycles → link_timeout=1, pwm_ref=0; the next valid frame clears link_timeout.
